// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types, defaults and helpers for the receive block assembler
package rx_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } rx_state_t;

   localparam int BLOCK_BYTES    = 16;
   localparam int FIFO_DEPTH     = 2;
   localparam int TIMEOUT_CYCLES = 100000;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/blk_fifo.sv
// rtl/blk_fifo.sv - first-word-fall-through block FIFO with occupancy count
module blk_fifo
   import rx_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             push_ok,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int CW = clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign valid   = (count != '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && valid;
   // A pop in the same cycle frees the slot the push needs
   assign push_ok = push && (!full || do_pop);
   assign head    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push_ok, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rx_block_assembler.sv
// rtl/rx_block_assembler.sv - gathers UART bytes into blocks and queues them; RX_TIMEOUT_EN adds an inter-byte timeout
module rx_block_assembler
   import rx_pkg::*;
#(
   parameter int BLOCK_BYTES    = rx_pkg::BLOCK_BYTES,
   parameter int FIFO_DEPTH     = rx_pkg::FIFO_DEPTH,
   parameter int TIMEOUT_CYCLES = rx_pkg::TIMEOUT_CYCLES,
   parameter int CNT_W          = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     byte_valid,
   input  logic [7:0]               byte_data,
   input  logic                     byte_err,
   output logic                     blk_valid,
   input  logic                     blk_ready,
   output logic [8*BLOCK_BYTES-1:0] blk_data,
   output logic                     busy,
   output logic                     fifo_full,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic                     err_pulse
);

   localparam int BW = 8 * BLOCK_BYTES;
   localparam int CW = clog2(BLOCK_BYTES);

   rx_state_t   state, state_nxt;
   logic [CW-1:0] count, count_nxt;
   logic [BW-1:0] shreg;
   logic          push, push_ok, discard, timeout, good, bad, drop_inc;

   assign good = byte_valid && !byte_err;
   assign bad  = byte_valid && byte_err;
   assign busy = (count != '0);

`ifdef RX_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] idle_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                            idle_cnt <= '0;
      else if (byte_valid || state != FILL) idle_cnt <= '0;
      else                                  idle_cnt <= idle_cnt + TW'(1);
   end

   // A byte on the expiry cycle wins over the timeout
   assign timeout = (state == FILL) && !byte_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      push      = 1'b0;
      discard   = 1'b0;
      case (state)
         IDLE: begin
            if (good) begin
               state_nxt = FILL;
               count_nxt = CW'(1);
            end
         end
         FILL: begin
            if (bad || timeout) begin
               discard   = 1'b1;
               state_nxt = IDLE;
               count_nxt = '0;
            end else if (good) begin
               if (count == CW'(BLOCK_BYTES - 1)) begin
                  push      = 1'b1;
                  state_nxt = IDLE;
                  count_nxt = '0;
               end else begin
                  count_nxt = count + CW'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = '0;
         end
      endcase
   end

   assign drop_inc = discard || (push && !push_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         shreg     <= '0;
         drop_cnt  <= '0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         err_pulse <= discard;
         if (good) shreg <= {shreg[BW-9:0], byte_data};
         if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

   blk_fifo #(
      .WIDTH (BW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({shreg[BW-9:0], byte_data}),
      .pop       (blk_ready),
      .push_ok   (push_ok),
      .valid     (blk_valid),
      .head      (blk_data),
      .full      (fifo_full)
   );

endmodule

// File: tb/tb_rx_block_assembler.sv
// tb/tb_rx_block_assembler.sv - randomized scoreboard bench for rx_block_assembler
module tb_rx_block_assembler;

   localparam int BB    = 16;
   localparam int DEPTH = 2;
   localparam int TO    = 50;
   localparam int CNT_W = 8;
   localparam int BW    = 8 * BB;

   logic             clk = 1'b0;
   logic             reset;
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             byte_err;
   logic             blk_valid;
   logic             blk_ready;
   logic [BW-1:0]    blk_data;
   logic             busy;
   logic             fifo_full;
   logic [CNT_W-1:0] drop_cnt;
   logic             err_pulse;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [7:0]    part[$];
   logic [BW-1:0] exp_q[$];
   int            occ = 0;
   int            exp_drop = 0;
   logic          exp_err = 1'b0;
   int            idle = 0;
   logic          mon_en = 1'b0;
   logic          pop_m, to_m, drop_m;
   logic [BW-1:0] blk_m;

   always #5 clk = ~clk;

   rx_block_assembler #(
      .BLOCK_BYTES    (BB),
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_err   (byte_err),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .blk_data   (blk_data),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .drop_cnt   (drop_cnt),
      .err_pulse  (err_pulse)
   );

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [7:0] d, input logic e, input logic r);
      byte_valid = v;
      byte_data  = d;
      byte_err   = e;
      blk_ready  = r;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      byte_err   = 1'b0;
   endtask

   // Behavioural model: bytes collect in a list; a full list becomes a block
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         part.delete();
         exp_q.delete();
         occ      = 0;
         exp_drop = 0;
         exp_err  = 1'b0;
         idle     = 0;
      end else begin
         pop_m   = blk_ready && (occ > 0);
         to_m    = 1'b0;
         drop_m  = 1'b0;
         exp_err = 1'b0;
`ifdef RX_TIMEOUT_EN
         to_m = (part.size() > 0) && !byte_valid && (idle == TO - 1);
         if (byte_valid || part.size() == 0 || to_m) idle = 0;
         else idle++;
`endif
         if ((byte_valid && byte_err) || to_m) begin
            if (part.size() > 0) begin
               part.delete();
               exp_err = 1'b1;
               drop_m  = 1'b1;
            end
         end else if (byte_valid) begin
            part.push_back(byte_data);
            if (part.size() == BB) begin
               blk_m = '0;
               foreach (part[i]) blk_m = (blk_m << 8) | BW'(part[i]);
               part.delete();
               if (occ < DEPTH || pop_m) begin
                  exp_q.push_back(blk_m);
                  occ++;
               end else begin
                  drop_m = 1'b1;
               end
            end
         end
         if (pop_m) occ--;
         if (drop_m && exp_drop < (1 << CNT_W) - 1) exp_drop++;
      end
   end

   // Monitor: compares DUT outputs against the model away from the clock edge
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         chk("blk_valid", BW'(blk_valid), BW'(occ > 0));
         chk("fifo_full", BW'(fifo_full), BW'(occ == DEPTH));
         chk("busy", BW'(busy), BW'(part.size() > 0));
         chk("drop_cnt", BW'(drop_cnt), BW'(exp_drop));
         chk("err_pulse", BW'(err_pulse), BW'(exp_err));
         if (blk_valid && exp_q.size() > 0) begin
            chk("blk_data", blk_data, exp_q[0]);
            if (blk_ready) void'(exp_q.pop_front());
         end
      end
   end

   int npulse;

   initial begin
      reset      = 1'b1;
      byte_valid = 1'b0;
      byte_data  = '0;
      byte_err   = 1'b0;
      blk_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_blk_valid", BW'(blk_valid), '0);
      chk("rst_blk_data", blk_data, '0);
      chk("rst_busy", BW'(busy), '0);
      chk("rst_fifo_full", BW'(fifo_full), '0);
      chk("rst_drop_cnt", BW'(drop_cnt), '0);
      chk("rst_err_pulse", BW'(err_pulse), '0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // counting bytes, popped at once
      for (int i = 0; i < BB; i++) cyc(1'b1, 8'(i), 1'b0, 1'b1);
      chk("t1_valid", BW'(blk_valid), BW'(1));
      chk("t1_data", blk_data, 128'h000102030405060708090a0b0c0d0e0f);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t1_popped", BW'(blk_valid), '0);
      chk("t1_drop", BW'(drop_cnt), '0);

      // three blocks into a two-deep FIFO with no reader
      for (int b = 0; b < 3; b++)
         for (int i = 0; i < BB; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
      chk("t2_full", BW'(fifo_full), BW'(1));
      chk("t2_drop", BW'(drop_cnt), BW'(1));
      repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b1);

      // last byte coincides with a pop while full
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < BB; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < BB - 1; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
      cyc(1'b1, 8'($urandom), 1'b0, 1'b1);
      chk("t3_full", BW'(fifo_full), BW'(1));
      chk("t3_drop", BW'(drop_cnt), BW'(1));
      repeat (5) cyc(1'b0, 8'h00, 1'b0, 1'b1);

      // framing error mid-block
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b1);
      cyc(1'b1, 8'($urandom), 1'b1, 1'b1);
      chk("t4_pulse", BW'(err_pulse), BW'(1));
      chk("t4_drop", BW'(drop_cnt), BW'(2));
      chk("t4_busy", BW'(busy), '0);
      cyc(1'b1, 8'h5a, 1'b1, 1'b1);
      chk("t4_pulse_once", BW'(err_pulse), '0);
      chk("t4_idle_err", BW'(drop_cnt), BW'(2));
      for (int i = 0; i < BB; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b1);
      repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b1);

      // random traffic with bursts of backpressure
      for (int n = 0; n < 3000; n++)
         cyc(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 39) == 0),
             (n % 400 < 150) ? 1'b0 : 1'($urandom));
      repeat (6) cyc(1'b0, 8'h00, 1'b0, 1'b1);

      // drop counter saturates
      for (int n = 0; n < 300; n++) begin
         cyc(1'b1, 8'($urandom), 1'b0, 1'b1);
         cyc(1'b1, 8'($urandom), 1'b1, 1'b1);
      end
      chk("sat_drop", BW'(drop_cnt), BW'(8'hff));

`ifdef RX_TIMEOUT_EN
      npulse = 0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b1);
      for (int i = 0; i < TO + 10; i++) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b1);
         if (err_pulse) npulse++;
      end
      chk("to_pulses", BW'(npulse), BW'(1));
      npulse = 0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b1);
      for (int i = 0; i < TO - 1; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 8'($urandom), 1'b0, 1'b1);
      if (err_pulse) npulse++;
      for (int i = 0; i < BB - 5; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b1);
      repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("to_late_byte", BW'(npulse), '0);
`endif

      // asynchronous reset with a queued block and a partial one
      for (int i = 0; i < BB + 7; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("arst_blk_valid", BW'(blk_valid), '0);
      chk("arst_blk_data", blk_data, '0);
      chk("arst_busy", BW'(busy), '0);
      chk("arst_fifo_full", BW'(fifo_full), '0);
      chk("arst_drop_cnt", BW'(drop_cnt), '0);
      chk("arst_err_pulse", BW'(err_pulse), '0);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < BB; i++) cyc(1'b1, 8'(8'hf0 - i), 1'b0, 1'b0);
      chk("post_rst_valid", BW'(blk_valid), BW'(1));
      repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("post_rst_drained", BW'(blk_valid), '0);
      chk("post_rst_drop", BW'(drop_cnt), '0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
